// File: rtl/uart_tx_arb_if.sv
// Bundles the requester side and transmitter side signals of the UART
// transmit scheduler. The arbiter uses the master view; the environment
// (byte sources plus transmitter) uses the slave view.
interface uart_tx_arb_if #(
    parameter int N  = 4,
    parameter int CW = 2,
    parameter int W  = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic           tx_busy;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic [N-1:0]   ack;
    logic [N-1:0]   err;
    logic [CW-1:0]  cur;
    logic           active;

    modport master (
        input  req, din, tx_busy,
        output tx_start, tx_data, ack, err, cur, active
    );

    modport slave (
        output req, din, tx_busy,
        input  tx_start, tx_data, ack, err, cur, active
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one UART transmitter among N byte sources.
// Latches the chosen byte, pulses tx_start, then follows tx_busy through the
// frame and returns a one-hot accept (ack) or start-timeout (err) pulse.
module uart_tx_arb #(
    parameter int N  = 4,
    parameter int CW = 2,
    parameter int W  = 8,
    parameter int TO = 15
) (
    input  logic              c,
    input  logic              r,
    uart_tx_arb_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_B,
        WAIT_D
    } state_t;

    state_t        state;
    logic [CW-1:0] ptr;
    logic [7:0]    cnt;
    logic          tx_start_q;
    logic [W-1:0]  tx_data_q;
    logic [N-1:0]  ack_q;
    logic [N-1:0]  err_q;
    logic [CW-1:0] cur_q;
    logic          active_q;

    logic [CW-1:0] sel;
    logic          any_req;

    // Pick the first requesting channel starting at ptr and wrapping; the
    // loop runs from the farthest offset down so the nearest one wins.
    always_comb begin
        sel     = ptr;
        any_req = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[ptr + CW'(i)]) begin
                sel     = ptr + CW'(i);
                any_req = 1'b1;
            end
        end
    end

    // Main scheduler FSM with all outputs registered; ack/err default low so
    // they only ever last a single cycle.
    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            cur_q      <= '0;
            active_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state)
                IDLE: begin
                    if (!bus.tx_busy && any_req) begin
                        tx_data_q  <= bus.din[int'(sel)*W +: W];
                        cur_q      <= sel;
                        tx_start_q <= 1'b1;
                        active_q   <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT_B;
                end
                WAIT_B: begin
                    if (bus.tx_busy) begin
                        ack_q[cur_q] <= 1'b1;
                        state        <= WAIT_D;
                    end else if (cnt == 8'(TO - 1)) begin
                        err_q[cur_q] <= 1'b1;
                        ptr          <= cur_q + CW'(1);
                        active_q     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_D: begin
                    if (!bus.tx_busy) begin
                        ptr      <= cur_q + CW'(1);
                        active_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.cur      = cur_q;
    assign bus.active   = active_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a table of transfers run back to back
// from one reset, plus hand-written busy hold-off and mid-transfer reset cases.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int W  = 8;
    localparam int TO = 15;
    localparam int BUSY_LEN = 20;

    logic c;
    logic r;
    logic model_on;
    logic model_busy;
    logic model_pend;
    int   model_left;
    logic ext_busy;

    int n_cmp;
    int n_bad;

    uart_tx_arb_if #(.N(N), .CW(CW), .W(W)) bus ();

    uart_tx_arb #(.N(N), .CW(CW), .W(W), .TO(TO)) dut (
        .c   (c),
        .r   (r),
        .bus (bus)
    );

    assign bus.tx_busy = model_busy | ext_busy;

    typedef struct {
        logic [N-1:0]   req_or;
        logic [N*W-1:0] din;
        bit             stuck;
        logic [CW-1:0]  cur;
        logic [W-1:0]   data;
        logic [N-1:0]   ack;
        logic [N-1:0]   err;
        int             lat;
        int             idle_lat;
    } vec_t;

    // Free-running clock, period 10.
    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    // Transmitter model: busy rises one cycle after a start pulse and stays
    // high for BUSY_LEN cycles; disabled when model_on is low.
    always @(negedge c) begin
        if (model_pend) begin
            model_pend = 1'b0;
            model_busy = 1'b1;
            model_left = BUSY_LEN;
        end else if (model_busy) begin
            model_left = model_left - 1;
            if (model_left == 0) model_busy = 1'b0;
        end
        if (model_on && bus.tx_start) model_pend = 1'b1;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Post a request, wait for the grant, then follow the transfer back to
    // IDLE, checking grant contents, pulse timing and absence of extra pulses.
    task automatic apply_stimulus(input vec_t v, output int wait_n);
        bit got_grant;
        bit got_pulse;
        bit back_idle;
        int lat;
        int idle_lat;
        int stray;
        logic [N-1:0] ack_v;
        logic [N-1:0] err_v;

        bus.req  = bus.req | v.req_or;
        bus.din  = v.din;
        model_on = !v.stuck;
        got_grant = 1'b0;
        wait_n    = 0;
        for (int w = 1; w <= 100; w++) begin
            @(negedge c);
            if (bus.tx_start) begin
                got_grant = 1'b1;
                wait_n    = w;
                break;
            end
        end
        check_output("grant_seen", 32'(got_grant), 32'd1);
        if (!got_grant) return;
        check_output("grant_cur", 32'(bus.cur), 32'(v.cur));
        check_output("grant_data", 32'(bus.tx_data), 32'(v.data));
        check_output("grant_active", 32'(bus.active), 32'd1);

        got_pulse = 1'b0;
        back_idle = 1'b0;
        lat = 0;
        idle_lat = 0;
        stray = 0;
        ack_v = '0;
        err_v = '0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge c);
            if (t == 1) check_output("start_width", 32'(bus.tx_start), 32'd0);
            if ((bus.ack | bus.err) != '0) begin
                if (!got_pulse) begin
                    got_pulse = 1'b1;
                    lat   = t;
                    ack_v = bus.ack;
                    err_v = bus.err;
                    bus.req[v.cur] = 1'b0;
                end else begin
                    stray++;
                end
            end
            if (!bus.active) begin
                back_idle = 1'b1;
                idle_lat  = t;
                break;
            end
        end
        check_output("pulse_seen", 32'(got_pulse), 32'd1);
        check_output("pulse_lat", 32'(lat), 32'(v.lat));
        check_output("ack_vec", 32'(ack_v), 32'(v.ack));
        check_output("err_vec", 32'(err_v), 32'(v.err));
        check_output("idle_seen", 32'(back_idle), 32'd1);
        check_output("idle_lat", 32'(idle_lat), 32'(v.idle_lat));
        check_output("stray_pulses", 32'(stray), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check_output({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check_output({tag, "_ack"}, 32'(bus.ack), 32'd0);
        check_output({tag, "_err"}, 32'(bus.err), 32'd0);
        check_output({tag, "_cur"}, 32'(bus.cur), 32'd0);
        check_output({tag, "_active"}, 32'(bus.active), 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int   wn;
        bit   saw;
        bit   got;
        vec_t hv;

        n_cmp = 0;
        n_bad = 0;
        model_on   = 1'b1;
        model_busy = 1'b0;
        model_pend = 1'b0;
        model_left = 0;
        ext_busy   = 1'b0;
        bus.req    = '0;
        bus.din    = 32'h4433_2211;
        r          = 1'b0;

        //            req_or   din           stk cur   data   ack      err      lat idle
        vecs[0]  = '{4'b1111, 32'h4433_2211, 0, 2'd0, 8'h11, 4'b0001, 4'b0000, 2, 22};
        vecs[1]  = '{4'b0000, 32'h4433_2211, 0, 2'd1, 8'h22, 4'b0010, 4'b0000, 2, 22};
        vecs[2]  = '{4'b0000, 32'h4433_2211, 0, 2'd2, 8'h33, 4'b0100, 4'b0000, 2, 22};
        vecs[3]  = '{4'b0000, 32'h4433_2211, 0, 2'd3, 8'h44, 4'b1000, 4'b0000, 2, 22};
        vecs[4]  = '{4'b0101, 32'h4433_2211, 0, 2'd0, 8'h11, 4'b0001, 4'b0000, 2, 22};
        vecs[5]  = '{4'b0001, 32'h4433_2211, 0, 2'd2, 8'h33, 4'b0100, 4'b0000, 2, 22};
        vecs[6]  = '{4'b0000, 32'h4433_2211, 0, 2'd0, 8'h11, 4'b0001, 4'b0000, 2, 22};
        vecs[7]  = '{4'b0100, 32'h4433_2211, 1, 2'd2, 8'h33, 4'b0000, 4'b0100, 16, 16};
        vecs[8]  = '{4'b1001, 32'h4433_2211, 0, 2'd3, 8'h44, 4'b1000, 4'b0000, 2, 22};
        vecs[9]  = '{4'b0000, 32'h4433_2211, 0, 2'd0, 8'h11, 4'b0001, 4'b0000, 2, 22};
        vecs[10] = '{4'b0010, 32'h4433_A511, 0, 2'd1, 8'hA5, 4'b0010, 4'b0000, 2, 22};

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge c);
        r = 1'b1;
        @(negedge c);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i], wn);
        end

        // Busy hold-off: no grant while the transmitter is externally busy.
        ext_busy = 1'b1;
        bus.req  = 4'b0001;
        saw = 1'b0;
        repeat (6) begin
            @(negedge c);
            saw = saw | bus.tx_start;
        end
        check_output("holdoff_no_start", 32'(saw), 32'd0);
        ext_busy = 1'b0;
        hv = '{4'b0001, 32'h4433_A511, 0, 2'd0, 8'h11, 4'b0001, 4'b0000, 2, 22};
        apply_stimulus(hv, wn);
        check_output("holdoff_grant_wait", 32'(wn), 32'd1);

        // Reset in WAIT_D with the transmitter still busy.
        bus.req = 4'b0010;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge c);
            if (bus.ack != '0) begin
                got = 1'b1;
                break;
            end
        end
        check_output("midreset_ack_seen", 32'(got), 32'd1);
        @(negedge c);
        r = 1'b0;
        #1;
        check_reset_outputs("midreset");
        saw = 1'b0;
        repeat (2) begin
            @(negedge c);
            saw = saw | (|bus.ack) | (|bus.err) | bus.tx_start;
        end
        check_output("midreset_quiet", 32'(saw), 32'd0);
        r = 1'b1;
        saw = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge c);
            #1;
            saw = saw | bus.tx_start;
            if (!model_busy) begin
                got = 1'b1;
                break;
            end
        end
        check_output("postreset_busy_fell", 32'(got), 32'd1);
        check_output("postreset_no_start", 32'(saw), 32'd0);
        hv = '{4'b0010, 32'h4433_A511, 0, 2'd1, 8'hA5, 4'b0010, 4'b0000, 2, 22};
        apply_stimulus(hv, wn);
        check_output("postreset_grant_wait", 32'(wn), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares one UART transmitter among N byte requesters. It latches one requester's byte and pulses the transmitter start. It then tracks the transmitter busy flag through the frame and returns a per-channel accept or timeout pulse. It sits between the application-side byte sources and the single UART transmit FSM, which has a one-cycle `tx_start` input, a parallel data input and a `tx_busy` output.

## Interface
- `N`, default 4: number of requesters; power of two, 2–8.
- `CW`, default 2: width of channel index; must equal log2(N).
- `W`, default 8: data byte width.
- `TO`, default 15: cycles allowed in WAIT_B for `tx_busy` to rise before abort; 2–255.

Ports:
- `c`  in  1  clock; all state changes on posedge.
- `r`  in  1  reset; asynchronous, active-low.
- `req`  in  N  per-channel request level; held with `din` slice stable until that channel's `ack` or `err`.
- `din`  in  N*W  channel i byte at bits [i*W +: W].
- `tx_busy`  in  1  transmitter busy, high for the frame duration.
- `tx_start`  out  1  one-cycle start pulse to transmitter, registered.
- `tx_data`  out  W  byte to transmitter; valid from the `tx_start` cycle, held until the next grant.
- `ack`  out  N  one-cycle pulse, one-hot: channel's byte accepted (transmitter went busy).
- `err`  out  N  one-cycle pulse, one-hot: start timeout for that channel.
- `cur`  out  CW  index of the currently or most recently granted channel.
- `active`  out  1  high from grant until return to IDLE.

## Operation
- States: IDLE, START, WAIT_B, WAIT_D. The encoding is not visible at the ports.
- Reset (r=0, immediate, also mid-transfer):
  - state=IDLE; `tx_start`=0, `tx_data`=0, `ack`=0, `err`=0, `cur`=0, `active`=0.
  - Round-robin pointer `ptr`=0; timeout counter=0.
  - A frame already started in the transmitter is not cancelled. After reset the arbiter waits in IDLE for `tx_busy`=0 before granting.
- IDLE: grant happens when `tx_busy`=0 and any `req` bit is set.
  - Selected channel: first set `req` bit searching ptr, ptr+1, … modulo N.
  - On the grant edge: `tx_data`<=`din` slice of the selected channel, `cur`<=selected channel, `tx_start`<=1, `active`<=1, state<=START.
  - If `tx_busy`=1 or no `req` is set: remain in IDLE and change no outputs.
- START: `tx_start`<=0; timeout counter<=0; state<=WAIT_B.
- WAIT_B:
  - If `tx_busy`=1: `ack[cur]`<=1 for one cycle; state<=WAIT_D.
  - Else if counter==TO-1: `err[cur]`<=1 for one cycle; `ptr`<=cur+1 mod N; `active`<=0; state<=IDLE.
  - Else: counter<=counter+1.
- WAIT_D: when `tx_busy`=0: `ptr`<=cur+1 mod N; `active`<=0; state<=IDLE.
- `ack` and `err` are never asserted in the same cycle. At most one bit of `ack`|`err` is high at any time.
- If `req[cur]` drops after the grant, the latched byte is still sent and `ack`/`err` still pulses.
- Requesters drop `req` in the cycle after `ack`. If a `req` is still high on return to IDLE, it re-competes at the lowest round-robin priority.
- `din` and `req` changes outside IDLE are ignored.
- Counter width is 8 bits. It never wraps, because the abort occurs at TO-1.

## Timing
- Grant edge k (IDLE, req set, busy low): `tx_start`=1 and `tx_data` valid during cycle k..k+1; `tx_start`=0 after edge k+1.
- Earliest `ack`: `tx_busy` sampled high at edge k+2 gives `ack` high during k+2..k+3.
- Timeout: with `tx_busy` held low, `err` rises at edge k+1+TO, i.e. TO cycles in WAIT_B.
- After `tx_busy` falls (sampled at edge m), state is IDLE after m. The next grant is at the earliest at edge m+1, so there is at least one IDLE cycle between transfers.
- Worst-case wait for any held request: N−1 full transfers.

## Test plan
- Single transfer: `req`=0010, `din[15:8]`=8'hA5; model busy 2 cycles after start for 20 cycles. Required: one `tx_start` pulse with `tx_data`=A5, `cur`=1, `ack`=0010 pulse, `active` low after busy falls.
- Simultaneous requests: `req`=1111 held, bytes 11/22/33/44, after reset. Required: grant order 0,1,2,3,0; each `ack` matches `tx_data`.
- Round-robin fairness: channel 0 re-requests immediately after each `ack` while channel 2 holds `req`. Required: channel 2 is granted before channel 0's second grant; grant order 0,2,0.
- Timeout: `req`=0100, `tx_busy` stuck 0, TO=15. Required: `err`=0100 exactly 15 cycles after the START cycle ends, no `ack`, `ptr`=3, and the next grant goes to channel 3 if requesting.
- Busy hold-off: `tx_busy`=1 externally while `req`=0001. Required: no `tx_start` until `tx_busy` falls, then a grant at the next edge.
- Reset mid-transfer: assert `r`=0 in WAIT_D with `tx_busy` high. Required: all outputs 0 immediately, no `ack` or `err`; after release, no grant while `tx_busy`=1.
